instr_fetch_buffer: RTL and testbench
=====================================

// Module: instr_fetch_buffer
// PURPOSE
//  Fetch stage directly downstream of the program counter. Issues instruction-memory
//  reads at the PC's i_addr and pulses pc_next to advance the PC on each accepted word.
//  Buffers fetched {pc, instr} pairs in a small FIFO that feeds decode.
//  Drops in-flight and buffered fetches on a branch/jump redirect (flush).
// PARAMETERS
//  DEPTH   2   FIFO entries; power of 2, range 2..8
//  ADDR_W  32  address/word width (word_t)
// PORTS
//  CLK          in   1       clock, rising edge
//  RST          in   1       synchronous reset, active-high
//  i_addr       in   ADDR_W  current PC from program counter
//  pc_next      out  1       advance-PC strobe to program counter
//  imemREN      out  1       instruction read enable to icache
//  imemaddr     out  ADDR_W  instruction read address, word aligned
//  ihit         in   1       icache hit; imemload valid this cycle
//  imemload     in   ADDR_W  instruction word from icache
//  flush        in   1       redirect; discard all fetched/pending instructions
//  dec_ready    in   1       decode accepts head entry this cycle
//  instr_valid  out  1       FIFO head valid
//  instr        out  ADDR_W  head instruction
//  instr_pc     out  ADDR_W  PC of head instruction
//  npc          out  ADDR_W  instr_pc + 4
// BEHAVIOUR
//  Reset: edge with RST=1 -> count=0, rd/wr ptr=0, state=FETCH. While RST=1, imemREN=0
//   and pc_next=0. Cycle after reset, instr_valid=0, instr/instr_pc=0, npc=4.
//  States: FETCH, FLUSH_WAIT.
//  FETCH:
//  - imemREN = (count < DEPTH).
//  - imemaddr = {i_addr[31:2],2'b00}.
//  - Accept = imemREN & ihit & !flush.
//  - On accept: push {imemaddr, imemload}. pc_next=1 in the same cycle (combinational).
//  - Steady ihit gives 1 instr/cycle.
//  Full: imemREN depends on count only, not on dec_ready. A same-cycle pop never
//   enables a push when count==DEPTH; imemREN reasserts the cycle after count<DEPTH.
//  Pop: instr_valid=(count!=0). Pop occurs on instr_valid & dec_ready & !flush.
//   Push+pop in one cycle leaves count unchanged.
//  Head outputs come from the FIFO read pointer. They hold stable while dec_ready=0.
//  Flush in FETCH:
//  - Next edge: count=0, pointers reset. No push and no pop that cycle. pc_next=0
//    (the PC loads its own redirect target).
//  - If imemREN=1 and ihit=0 at flush: latch imemaddr into held_addr -> FLUSH_WAIT.
//  - If ihit=1 at flush: the word is discarded, state stays FETCH.
//  FLUSH_WAIT:
//  - imemREN=1, imemaddr=held_addr, pc_next=0, instr_valid=0.
//  - On ihit: data discarded -> FETCH.
//  - Further flush while waiting: no effect, state stays FLUSH_WAIT.
//  - Reason: the icache requires REN/addr stable until hit.
//  Flush with pop the same cycle: flush wins; the entry is not consumed.
//  npc: 32-bit add, wraps (0xFFFFFFFC -> 0x00000000).
//  RST mid-operation (any state): same as reset; the pending miss is abandoned.
// TESTING
//  1. ihit=1 always, dec_ready=1, i_addr 0,4,8 -> pc_next=1 each cycle; instr_pc 0,4,8
//     one cycle later; npc 4,8,C.
//  2. DEPTH=2, dec_ready=0, ihit=1 -> two pushes, then imemREN=0 and pc_next=0.
//     Set dec_ready=1 -> pop, imemREN=1 the next cycle; head holds while stalled.
//  3. Miss at 0x40 (ihit=0), flush asserted, PC moves to 0x100 -> FLUSH_WAIT with
//     imemaddr=0x40. ihit after 3 cycles: word dropped, then imemaddr=0x100; nothing
//     from 0x40 reaches decode.
//  4. FIFO holds 2 entries, flush=1 with dec_ready=1 -> instr_valid=0 next cycle;
//     entries never seen by decode.
//  5. Push at i_addr=0xFFFFFFFC -> instr_pc=0xFFFFFFFC, npc=0x00000000.
//  6. RST=1 during FLUSH_WAIT -> next cycle state=FETCH, count=0, imemREN=0 while
//     RST high, outputs at reset values.

Source files
------------

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: issues icache reads at the current PC, advances the PC on every
// accepted word, and queues {pc, instr} pairs for decode. A redirect (flush)
// drops queued words; an outstanding miss is held until the icache answers.
module instr_fetch_buffer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              pc_next,
    output logic              imemREN,
    output logic [ADDR_W-1:0] imemaddr,
    input  logic              ihit,
    input  logic [ADDR_W-1:0] imemload,
    input  logic              flush,
    input  logic              dec_ready,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] npc
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        FETCH      = 1'b0,
        FLUSH_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] held_addr;
    logic [ADDR_W-1:0] held_addr_nxt;

    logic [ADDR_W-1:0] mem_pc    [DEPTH];
    logic [ADDR_W-1:0] mem_instr [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic push;
    logic pop;
    logic clear;

    // Low PC bits never reach the icache; fetches are word aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[1:0];

    assign full        = (count == CNT_W'(DEPTH));
    assign instr_valid = (count != '0);

    // Head of the queue; forced to zero when empty so reset/flush outputs are defined.
    always_comb begin
        instr    = '0;
        instr_pc = '0;
        if (instr_valid) begin
            instr    = mem_instr[rd_ptr];
            instr_pc = mem_pc[rd_ptr];
        end
    end

    assign npc = instr_pc + ADDR_W'(4);

    // Next state, icache request, PC strobe and queue controls.
    always_comb begin
        state_nxt     = state;
        held_addr_nxt = held_addr;
        imemREN       = 1'b0;
        imemaddr      = {i_addr[ADDR_W-1:2], 2'b00};
        pc_next       = 1'b0;
        push          = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        if (!RST) begin
            case (state)
                FETCH: begin
                    imemREN = !full;
                    push    = imemREN && ihit && !flush;
                    pc_next = push;
                    pop     = instr_valid && dec_ready && !flush;
                    if (flush) begin
                        clear = 1'b1;
                        // Icache needs REN/addr stable until it answers a miss.
                        if (imemREN && !ihit) begin
                            held_addr_nxt = imemaddr;
                            state_nxt     = FLUSH_WAIT;
                        end
                    end
                end
                FLUSH_WAIT: begin
                    imemREN  = 1'b1;
                    imemaddr = held_addr;
                    if (ihit) begin
                        state_nxt = FETCH;
                    end
                end
                default: state_nxt = FETCH;
            endcase
        end
    end

    // State, held miss address, pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= FETCH;
            held_addr <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            held_addr <= held_addr_nxt;
            if (clear) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

    // Queue storage; contents are don't-care while the slot is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_pc[wr_ptr]    <= imemaddr;
            mem_instr[wr_ptr] <= imemload;
        end
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Bench for instr_fetch_buffer: directed scenarios plus random traffic,
// checked against a reference queue model every cycle.
module tb_instr_fetch_buffer;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned ADDR_W = 32;

    logic              CLK;
    logic              RST;
    logic [ADDR_W-1:0] i_addr;
    logic              pc_next;
    logic              imemREN;
    logic [ADDR_W-1:0] imemaddr;
    logic              ihit;
    logic [ADDR_W-1:0] imemload;
    logic              flush;
    logic              dec_ready;
    logic              instr_valid;
    logic [ADDR_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] npc;

    instr_fetch_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_addr     (i_addr),
        .pc_next    (pc_next),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .flush      (flush),
        .dec_ready  (dec_ready),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .npc        (npc)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: expected queue of {pc, instr}, miss-hold state.
    logic [63:0] exp_q[$];
    logic        m_wait = 1'b0;
    logic [31:0] m_held = '0;
    logic [31:0] pc     = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1357_9BDF;
    endfunction

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic step(input logic rst_i, input logic [31:0] addr_i, input logic hit_i,
                        input logic fl_i, input logic rdy_i);
        logic [31:0] e_addr;
        logic        e_ren;
        logic        e_acc;
        logic        e_pop;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        @(negedge CLK);
        RST       = rst_i;
        i_addr    = addr_i;
        ihit      = hit_i;
        flush     = fl_i;
        dec_ready = rdy_i;
        e_addr    = m_wait ? m_held : {addr_i[31:2], 2'b00};
        imemload  = word_of(e_addr);
        e_ren     = rst_i ? 1'b0 : (m_wait ? 1'b1 : (exp_q.size() < DEPTH));
        e_acc     = !rst_i && !m_wait && e_ren && hit_i && !fl_i;
        e_valid   = (exp_q.size() != 0);
        e_pop     = !rst_i && !m_wait && e_valid && rdy_i && !fl_i;
        e_pc      = e_valid ? exp_q[0][63:32] : 32'h0;
        e_instr   = e_valid ? exp_q[0][31:0]  : 32'h0;
        #1;
        check_eq("imemREN", {31'b0, imemREN}, {31'b0, e_ren});
        check_eq("pc_next", {31'b0, pc_next}, {31'b0, e_acc});
        if (e_ren) check_eq("imemaddr", imemaddr, e_addr);
        check_eq("instr_valid", {31'b0, instr_valid}, {31'b0, e_valid});
        check_eq("instr", instr, e_instr);
        check_eq("instr_pc", instr_pc, e_pc);
        check_eq("npc", npc, e_pc + 32'd4);
        if (rst_i) begin
            exp_q.delete();
            m_wait = 1'b0;
        end else if (!m_wait) begin
            if (fl_i) begin
                exp_q.delete();
                if (e_ren && !hit_i) begin
                    m_wait = 1'b1;
                    m_held = e_addr;
                end
            end else begin
                if (e_pop) void'(exp_q.pop_front());
                if (e_acc) exp_q.push_back({e_addr, word_of(e_addr)});
            end
        end else if (hit_i) begin
            m_wait = 1'b0;
        end
        if (e_acc) pc = e_addr + 32'd4;
    endtask

    initial begin
        CLK       = 1'b0;
        RST       = 1'b1;
        i_addr    = '0;
        ihit      = 1'b0;
        imemload  = '0;
        flush     = 1'b0;
        dec_ready = 1'b0;

        // Reset
        step(1, 32'h0, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0);

        // Streaming at one word per cycle
        step(0, 32'h0, 1, 0, 1);
        step(0, 32'h4, 1, 0, 1);
        step(0, 32'h8, 1, 0, 1);
        step(0, 32'hC, 0, 0, 1);
        step(0, 32'hC, 0, 0, 1);

        // Fill to full, stall, then release
        step(0, 32'h20, 1, 0, 0);
        step(0, 32'h24, 1, 0, 0);
        step(0, 32'h28, 1, 0, 0);
        step(0, 32'h28, 1, 0, 0);
        step(0, 32'h28, 1, 0, 1);
        step(0, 32'h28, 1, 0, 1);
        step(0, 32'h2C, 0, 0, 1);
        step(0, 32'h2C, 0, 0, 1);
        step(0, 32'h2C, 0, 0, 1);

        // Miss then redirect: held address until the late hit
        step(0, 32'h40, 0, 0, 1);
        step(0, 32'h41, 0, 1, 1);
        step(0, 32'h100, 0, 0, 1);
        step(0, 32'h100, 0, 1, 1);
        step(0, 32'h100, 1, 0, 1);
        step(0, 32'h100, 0, 0, 1);
        step(0, 32'h100, 1, 0, 1);
        step(0, 32'h104, 0, 0, 1);

        // Flush beats a same-cycle pop on a full queue
        step(0, 32'h200, 1, 0, 0);
        step(0, 32'h204, 1, 0, 0);
        step(0, 32'h208, 1, 1, 1);
        step(0, 32'h300, 0, 0, 1);

        // Address wrap of npc
        step(0, 32'hFFFF_FFFC, 1, 0, 0);
        step(0, 32'h0, 0, 0, 0);
        step(0, 32'h0, 0, 0, 1);
        step(0, 32'h0, 0, 0, 1);

        // Reset while holding a miss
        step(0, 32'h500, 0, 1, 0);
        step(0, 32'h600, 0, 0, 0);
        step(1, 32'h600, 0, 0, 0);
        step(1, 32'h600, 1, 0, 0);
        step(0, 32'h600, 0, 0, 0);
        step(0, 32'h600, 1, 0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rst;
            logic        r_fl;
            logic [31:0] a;
            r_rst = ($urandom_range(0, 59) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            a     = pc | 32'($urandom_range(0, 3));
            if (r_fl) pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            step(r_rst, a, ($urandom_range(0, 2) != 0), r_fl, $urandom_range(0, 1) == 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
